// File: rtl/package_param.sv
// Fetch-stage shared definitions: FSM state encoding, reset PC, NOP word and RV32I major opcodes.
// Pure declarations; no timing or flow-control behaviour of its own.
package package_param;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_HOLD = 2'd2,
    F_TRAP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its +4 incrementer; loads next_pc when load is high.
// One-cycle update; the fetch FSM decides when load may fire.
module pc_reg
  import package_param::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_four
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else if (load) begin
      pc <= next_pc;
    end
  end

  // 32-bit add wraps naturally: 32'hFFFF_FFFC + 4 = 0
  assign pc_four = pc + 32'd4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, instruction held until consumed (2 cycles min per instr).
// i_stall holds the current instruction in F_HOLD; a misaligned redirect traps until reset.
module fetch_unit
  import package_param::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic [31:0] o_instr,
  output logic        o_instr_vld,
  output logic        o_misalign
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_four;
  logic [31:0]  next_pc;
  logic         consume;
  logic         bad_redirect;
  logic         pc_load;

  // o_instr_vld is only ever high in F_HOLD, so it doubles as the hold-state qualifier
  assign consume      = o_instr_vld & ~i_stall;
  assign bad_redirect = i_pc_sel & misaligned(i_alu_data);
  assign pc_load      = consume & ~bad_redirect;
  assign next_pc      = i_pc_sel ? i_alu_data : pc_four;

  pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk     (i_clk),
    .reset   (i_reset),
    .load    (pc_load),
    .next_pc (next_pc),
    .pc      (pc),
    .pc_four (pc_four)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= F_REQ;
      o_instr     <= NOP_INSTR;
      o_instr_vld <= 1'b0;
      o_misalign  <= 1'b0;
    end else begin
      case (state)
        F_REQ: begin
          if (i_imem_gnt) begin
            if (i_imem_rvalid) begin
              o_instr     <= i_imem_rdata;
              o_instr_vld <= 1'b1;
              state       <= F_HOLD;
            end else begin
              state <= F_WAIT;
            end
          end
        end
        F_WAIT: begin
          if (i_imem_rvalid) begin
            o_instr     <= i_imem_rdata;
            o_instr_vld <= 1'b1;
            state       <= F_HOLD;
          end
        end
        F_HOLD: begin
          if (consume) begin
            o_instr_vld <= 1'b0;
            if (bad_redirect) begin
              o_misalign <= 1'b1;
              state      <= F_TRAP;
            end else begin
              state <= F_REQ;
            end
          end
        end
        F_TRAP: begin
          state <= F_TRAP;
        end
        default: begin
          state <= F_TRAP;
        end
      endcase
    end
  end

  assign o_imem_req  = (state == F_REQ);
  assign o_imem_addr = pc;
  assign o_pc        = pc;
  assign o_pc_four   = pc_four;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: delay-programmable memory responder plus a transaction-level PC model.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        i_clk;
  logic        i_reset;
  logic        i_pc_sel;
  logic [31:0] i_alu_data;
  logic        i_stall;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic [31:0] o_instr;
  logic        o_instr_vld;
  logic        o_misalign;

  int          checks;
  int          failures;
  int          mem_g;
  int          mem_r;
  int          inject_cnt;
  logic [31:0] exp_pc;
  bit          exp_trap;

  fetch_unit #(.RESET_VECTOR(RV)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_pc_sel      (i_pc_sel),
    .i_alu_data    (i_alu_data),
    .i_stall       (i_stall),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_pc          (o_pc),
    .o_pc_four     (o_pc_four),
    .o_instr       (o_instr),
    .o_instr_vld   (o_instr_vld),
    .o_misalign    (o_misalign)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0033;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Memory: mem_g request cycles without grant, then grant; data mem_r cycles after grant (0 = same cycle)
  initial begin
    int          cnt;
    int          rcnt;
    bit          busy;
    logic [31:0] addr;
    cnt = 0; rcnt = 0; busy = 0; addr = 32'h0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    forever begin
      @(negedge i_clk);
      #1;
      i_imem_gnt    = 1'b0;
      i_imem_rvalid = 1'b0;
      if (i_reset) begin
        busy = 0;
        cnt  = 0;
      end else if (busy) begin
        rcnt++;
        if (rcnt >= mem_r) begin
          i_imem_rvalid = 1'b1;
          i_imem_rdata  = mem_word(addr);
          busy = 0;
        end
      end else if (o_imem_req === 1'b1) begin
        if (cnt < mem_g) begin
          cnt++;
        end else begin
          i_imem_gnt = 1'b1;
          cnt  = 0;
          addr = o_imem_addr;
          if (mem_r == 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(addr);
          end else begin
            busy = 1;
            rcnt = 0;
          end
        end
      end
      if (inject_cnt > 0) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'hDEAD_BEEF;
        inject_cnt--;
      end
    end
  end

  // Starts at a negedge with the DUT requesting; ends at the negedge after the consume cycle.
  task automatic fetch_one(input int g, input int r, input int nstall, input bit sel, input logic [31:0] tgt);
    int          lat;
    logic [31:0] pf;
    logic [31:0] ew;
    mem_g = g;
    mem_r = r;
    pf = exp_pc + 32'd4;
    ew = mem_word(exp_pc);
    checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== exp_pc) begin
      failures++;
      $display("FAIL req_start req=%b addr=%h expected req=1 addr=%h", o_imem_req, o_imem_addr, exp_pc);
    end
    lat = 0;
    while (o_instr_vld !== 1'b1 && lat < 100) begin
      @(negedge i_clk);
      lat++;
      if (o_imem_req === 1'b1) begin
        checks++;
        if (o_imem_addr !== exp_pc) begin
          failures++;
          $display("FAIL addr_hold addr=%h expected %h", o_imem_addr, exp_pc);
        end
      end
    end
    checks++;
    if (lat !== g + r + 1) begin
      failures++;
      $display("FAIL latency got=%0d expected=%0d (g=%0d r=%0d)", lat, g + r + 1, g, r);
    end
    checks++;
    if (o_instr !== ew || o_pc !== exp_pc || o_pc_four !== pf || o_imem_req !== 1'b0) begin
      failures++;
      $display("FAIL deliver instr=%h pc=%h pc4=%h req=%b expected instr=%h pc=%h pc4=%h req=0",
               o_instr, o_pc, o_pc_four, o_imem_req, ew, exp_pc, pf);
    end
    for (int k = 0; k < nstall; k++) begin
      i_stall    = 1'b1;
      i_pc_sel   = 1'($urandom_range(0, 1));
      i_alu_data = $urandom;
      @(negedge i_clk);
      checks++;
      if (o_instr_vld !== 1'b1 || o_instr !== ew || o_pc !== exp_pc || o_imem_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold vld=%b instr=%h pc=%h req=%b expected vld=1 instr=%h pc=%h req=0",
                 o_instr_vld, o_instr, o_pc, o_imem_req, ew, exp_pc);
      end
    end
    i_stall    = 1'b0;
    i_pc_sel   = sel;
    i_alu_data = tgt;
    @(negedge i_clk);
    i_pc_sel = 1'b0;
    if (sel && tgt[1:0] != 2'b00) exp_trap = 1'b1;
    else if (sel) exp_pc = tgt;
    else exp_pc = pf;
    checks++;
    if (o_instr_vld !== 1'b0 || o_misalign !== exp_trap) begin
      failures++;
      $display("FAIL after_consume vld=%b misalign=%b expected vld=0 misalign=%b", o_instr_vld, o_misalign, exp_trap);
    end
  endtask

  task automatic test_reset();
    i_reset  = 1'b1;
    i_stall  = 1'b0;
    i_pc_sel = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_instr_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b expected 0", o_instr_vld); end
    checks++;
    if (o_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b expected 0", o_misalign); end
    checks++;
    if (o_pc !== RV) begin failures++; $display("FAIL reset_pc got=%h expected %h", o_pc, RV); end
    checks++;
    if (o_instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr got=%h expected 00000013", o_instr); end
    checks++;
    if (o_pc_four !== 32'h0000_0004) begin failures++; $display("FAIL reset_pc_four got=%h expected 00000004", o_pc_four); end
    i_reset  = 1'b0;
    exp_pc   = RV;
    exp_trap = 1'b0;
  endtask

  task automatic test_zero_wait();
    fetch_one(0, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_slow_mem();
    fetch_one(3, 2, 0, 1'b0, 32'h0);
  endtask

  task automatic test_stall();
    fetch_one(0, 1, 4, 1'b0, 32'h0);
    fetch_one(0, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_redirect();
    fetch_one(0, 0, 3, 1'b1, 32'h0000_0100);
    fetch_one(1, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    fetch_one(0, 0, 0, 1'b1, 32'hFFFF_FFFC);
    fetch_one(0, 0, 0, 1'b0, 32'h0);
    fetch_one(0, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) fetch_one(0, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] tgt;
      bit          sel;
      tgt      = $urandom;
      tgt[1:0] = 2'b00;
      sel      = ($urandom_range(0, 3) == 0);
      fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), sel, tgt);
    end
  endtask

  task automatic test_reset_in_wait();
    mem_g = 0;
    mem_r = 5;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_instr_vld !== 1'b0 || o_imem_req !== 1'b0) begin
      failures++;
      $display("FAIL wait_state vld=%b req=%b expected vld=0 req=0", o_instr_vld, o_imem_req);
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_instr_vld !== 1'b0 || o_instr !== 32'h0000_0013 || o_pc !== RV) begin
      failures++;
      $display("FAIL reset_in_wait vld=%b instr=%h pc=%h expected vld=0 instr=00000013 pc=%h", o_instr_vld, o_instr, o_pc, RV);
    end
    i_reset    = 1'b0;
    exp_pc     = RV;
    inject_cnt = 1;
    fetch_one(2, 1, 0, 1'b0, 32'h0);
  endtask

  task automatic test_misalign();
    fetch_one(0, 0, 0, 1'b1, 32'h0000_0102);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      checks++;
      if (o_misalign !== 1'b1 || o_instr_vld !== 1'b0 || o_imem_req !== 1'b0 || o_pc !== exp_pc) begin
        failures++;
        $display("FAIL trap misalign=%b vld=%b req=%b pc=%h expected misalign=1 vld=0 req=0 pc=%h",
                 o_misalign, o_instr_vld, o_imem_req, o_pc, exp_pc);
      end
    end
    test_reset();
    fetch_one(0, 0, 0, 1'b0, 32'h0);
  endtask

  initial begin
    checks = 0; failures = 0;
    i_reset = 1'b1; i_stall = 1'b0; i_pc_sel = 1'b0; i_alu_data = 32'h0;
    mem_g = 0; mem_r = 0; inject_cnt = 0;
    exp_pc = RV; exp_trap = 1'b0;
    test_reset();
    test_zero_wait();
    test_slow_mem();
    test_stall();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_in_wait();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
